// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP responder.
package jtag_pkg;

  localparam int IR_W = 5;

  // TAP controller states, encoded as in the IEEE 1149.1 reference controller.
  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_BYPASS  = 5'h1F;
  localparam logic [IR_W-1:0] OP_IDCODE  = 5'h01;
  localparam logic [IR_W-1:0] OP_USER    = 5'h11;
  localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00001;

  // One-cycle action strobes: each fires on the TCK rise that leaves its state.
  typedef struct packed {
    logic test_reset;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
  } tap_strobes_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller, advanced by the oversampled TCK rise strobe.
//
// state    | meaning
// ---------+------------------------------------------------
// TLR  (F) | test-logic-reset, instruction forced to reset op
// RTI  (C) | run-test/idle
// SelDR(7) | select DR scan
// CapDR(6) | capture selected DR into the shift register
// ShDR (2) | shift DR, TDI in at the top, TDO from bit 0
// Ex1DR(1) | exit-1 DR
// PausDR(3)| pause DR
// Ex2DR(0) | exit-2 DR
// UpdDR(5) | update DR (user word offered downstream)
// SelIR(4) | select IR scan
// CapIR(E) | capture 5'b00001 into the IR shift register
// ShIR (A) | shift IR
// Ex1IR(9) | exit-1 IR
// PausIR(B)| pause IR
// Ex2IR(8) | exit-2 IR
// UpdIR(D) | update IR (active instruction loaded)
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rise,
  input  logic         tms,
  output tap_state_t   state,
  output tap_strobes_t strobes
);

  tap_state_t state_next;

  // State register: moves only on a detected TCK rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TAP_TLR;
    end else if (rise) begin
      state <= state_next;
    end
  end

  // Next-state decode from TMS.
  always_comb begin
    state_next = state;
    unique case (state)
      TAP_TLR:      state_next = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      state_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   state_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:    state_next = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR:   state_next = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_next = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   state_next = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   state_next = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   state_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:    state_next = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR:   state_next = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_next = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   state_next = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR : TAP_RTI;
      default:      state_next = TAP_TLR;
    endcase
  end

  // Action strobes for the rise that leaves the current state.
  always_comb begin
    strobes = '0;
    if (rise) begin
      case (state)
        TAP_TLR:    strobes.test_reset = 1'b1;
        TAP_CAP_IR: strobes.capture_ir = 1'b1;
        TAP_SH_IR:  strobes.shift_ir   = 1'b1;
        TAP_UPD_IR: strobes.update_ir  = 1'b1;
        TAP_CAP_DR: strobes.capture_dr = 1'b1;
        TAP_SH_DR:  strobes.shift_dr   = 1'b1;
        TAP_UPD_DR: strobes.update_dr  = 1'b1;
        default:    strobes = '0;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP for the remote-bitbang debug link, oversampled in clk.
// Provides BYPASS, a 32-bit user DR with a valid/ready update port, and
// optionally IDCODE when JTAG_TAP_IDCODE_EN is defined (reset instruction is
// then IDCODE; otherwise the IDCODE parameters do not exist and reset is BYPASS).
module jtag_tap_responder
  import jtag_pkg::tap_state_t, jtag_pkg::tap_strobes_t, jtag_pkg::TAP_SH_IR,
         jtag_pkg::TAP_SH_DR, jtag_pkg::OP_BYPASS, jtag_pkg::IR_CAPTURE;
#(
  parameter int              IR_W         = jtag_pkg::IR_W,
`ifdef JTAG_TAP_IDCODE_EN
  parameter logic [31:0]     IDCODE_VALUE = 32'h1000_05A3,
  parameter logic [IR_W-1:0] IR_IDCODE    = 5'h01,
`endif
  parameter logic [IR_W-1:0] IR_USER      = 5'h11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tclk,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir,
  input  logic [31:0]     user_capture_data,
  output logic            user_update_valid,
  output logic [31:0]     user_update_data,
  input  logic            user_update_ready,
  output logic            user_overrun
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] OP_RESET = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] OP_RESET = IR_W'(OP_BYPASS);
`endif

  logic         tclk_q;
  logic         armed;
  logic         rise;
  logic         fall;
  tap_state_t   state;
  tap_strobes_t strobes;
  logic [IR_W-1:0] ir_shift;
  logic [31:0]  dr_shift;
  logic [31:0]  dr_capture;
  logic         dr_bypass;
  logic         offer;

  // armed masks the first cycle after reset so a TCK already high is not a rise.
  assign rise = tclk & ~tclk_q & armed;
  assign fall = ~tclk & tclk_q;

  // TCK edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      tclk_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      tclk_q <= tclk;
      armed  <= 1'b1;
    end
  end

  jtag_tap_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .rise    (rise),
    .tms     (tms),
    .state   (state),
    .strobes (strobes)
  );

  assign tap_state = state;

  // DR selection by the active instruction.
  always_comb begin
    dr_capture = '0;
    dr_bypass  = 1'b1;
    if (ir == IR_USER) begin
      dr_capture = user_capture_data;
      dr_bypass  = 1'b0;
    end
`ifdef JTAG_TAP_IDCODE_EN
    else if (ir == IR_IDCODE) begin
      dr_capture = IDCODE_VALUE;
      dr_bypass  = 1'b0;
    end
`endif
  end

  // Instruction and data shift registers, updated on TCK rise actions.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= OP_RESET;
      ir_shift <= '0;
      dr_shift <= '0;
    end else begin
      if (strobes.test_reset) ir <= OP_RESET;
      if (strobes.capture_ir) ir_shift <= IR_W'(IR_CAPTURE);
      if (strobes.shift_ir)   ir_shift <= {tdi, ir_shift[IR_W-1:1]};
      if (strobes.update_ir)  ir <= ir_shift;
      if (strobes.capture_dr) dr_shift <= dr_capture;
      if (strobes.shift_dr)   dr_shift <= dr_bypass ? {31'b0, tdi} : {tdi, dr_shift[31:1]};
    end
  end

  // TDO changes on TCK fall so the host samples a stable bit before the next rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo <= 1'b0;
    end else if (fall) begin
      if (state == TAP_SH_IR)      tdo <= ir_shift[0];
      else if (state == TAP_SH_DR) tdo <= dr_shift[0];
      else                         tdo <= 1'b0;
    end
  end

  assign offer = strobes.update_dr & (ir == IR_USER);

  // Update handshake: an accept in the same cycle frees the slot for a new offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      user_update_valid <= 1'b0;
      user_update_data  <= '0;
      user_overrun      <= 1'b0;
    end else if (offer && (!user_update_valid || user_update_ready)) begin
      user_update_valid <= 1'b1;
      user_update_data  <= dr_shift;
    end else if (offer) begin
      user_overrun      <= 1'b1;
    end else if (user_update_valid && user_update_ready) begin
      user_update_valid <= 1'b0;
    end
  end

endmodule
